// File: rtl/spi_slave_top_if.sv
// Signal bundle between the TRSQ8 CPU bus plus SPI pins and the SPI slave peripheral.
// The slave modport is the peripheral's view; the master modport is the CPU/pad side.
interface spi_slave_top_if;
   logic [7:0] addr;
   logic [7:0] dout;
   logic [7:0] din;
   logic       wr_en;
   logic       rd_en;
   logic       sclk;
   logic       mosi;
   logic       ss_n;
   logic       miso;
   logic       miso_oe;

   modport slave (
      input  addr, dout, wr_en, rd_en, sclk, mosi, ss_n,
      output din, miso, miso_oe
   );

   modport master (
      output addr, dout, wr_en, rd_en, sclk, mosi, ss_n,
      input  din, miso, miso_oe
   );
endinterface

// File: rtl/spi_slave_top.sv
// Memory-mapped SPI slave: one TX and one RX byte buffer, MSB first, 8-bit frames,
// CPOL/CPHA modes 0-3, with the SPI pins resynchronised into the clk domain.
module spi_slave_top #(
   parameter logic [7:0] BASE_ADDR = 8'h84,
   parameter logic [7:0] LAST_ADDR = 8'h87
) (
   input logic           clk,
   input logic           reset,
   spi_slave_top_if.slave bus
);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

   state_t     r_state;
   state_t     w_nextState;
   logic [2:0] r_sclkSync;
   logic [1:0] r_mosiSync;
   logic [2:0] r_ssnSync;
   logic       r_en;
   logic       r_cpol;
   logic       r_cpha;
   logic       r_rxf;
   logic       r_txe;
   logic       r_ovr;
   logic [7:0] r_txBuf;
   logic [7:0] r_rxBuf;
   logic [7:0] r_shRx;
   logic [7:0] r_shTx;
   logic [2:0] r_bitCnt;
   logic [7:0] r_rdData;

   logic       w_inWindow;
   logic [1:0] w_loc;
   logic       w_wr;
   logic       w_rd;
   logic       w_wrCon;
   logic       w_wrStat;
   logic       w_wrTx;
   logic       w_rdRx;
   logic       w_enOff;
   logic       w_sclkEdge;
   logic       w_leading;
   logic       w_trailing;
   logic       w_sampleEdge;
   logic       w_shiftEdge;
   logic       w_ssnFall;
   logic       w_ssnRise;
   logic       w_start;
   logic       w_stop;
   logic       w_sample;
   logic       w_shift;
   logic       w_byteDone;
   logic       w_loadTx;
   logic       w_sel;
   logic       w_busy;
   logic [7:0] w_rxByte;
   logic [7:0] w_regVal;
   logic       w_unusedBits;

   // Bus decode: write takes priority, so a simultaneous read is dropped entirely.
   assign w_inWindow = (bus.addr >= BASE_ADDR) && (bus.addr <= LAST_ADDR);
   assign w_loc      = bus.addr[1:0];
   assign w_wr       = bus.wr_en && w_inWindow;
   assign w_rd       = bus.rd_en && !bus.wr_en && w_inWindow;
   assign w_wrCon    = w_wr && (w_loc == 2'd0);
   assign w_wrStat   = w_wr && (w_loc == 2'd1);
   assign w_wrTx     = w_wr && (w_loc == 2'd2);
   assign w_rdRx     = w_rd && (w_loc == 2'd3);
   assign w_enOff    = w_wrCon && !bus.dout[0];

   // Edges come from comparing the 2nd and 3rd sync stages, so mosi stage 2 lines up with them.
   assign w_sclkEdge   = r_sclkSync[1] ^ r_sclkSync[2];
   assign w_leading    = w_sclkEdge && (r_sclkSync[1] != r_cpol);
   assign w_trailing   = w_sclkEdge && (r_sclkSync[1] == r_cpol);
   assign w_sampleEdge = r_cpha ? w_trailing : w_leading;
   assign w_shiftEdge  = r_cpha ? w_leading : w_trailing;
   assign w_ssnFall    = !r_ssnSync[1] && r_ssnSync[2];
   assign w_ssnRise    = r_ssnSync[1] && !r_ssnSync[2];

   assign w_sample   = (r_state == ST_ACTIVE) && !w_stop && w_sampleEdge;
   assign w_shift    = (r_state == ST_ACTIVE) && !w_stop && w_shiftEdge;
   assign w_byteDone = w_sample && (r_bitCnt == 3'd7);
   assign w_rxByte   = {r_shRx[6:0], r_mosiSync[1]};
   assign w_loadTx   = w_start || (w_byteDone && r_cpha) ||
                       (w_shift && (r_bitCnt == 3'd0) && !r_cpha);
   assign w_sel      = (r_state == ST_ACTIVE);
   assign w_busy     = (r_bitCnt != 3'd0);

   assign w_unusedBits = ^{bus.dout[7:3], r_shRx[7]};

   assign bus.miso_oe = r_en && w_sel;
   assign bus.miso    = bus.miso_oe && r_shTx[7];
   assign bus.din     = w_inWindow ? r_rdData : 8'hZZ;

   always_comb begin
      w_regVal = 8'h00;
      case (w_loc)
         2'd0:    w_regVal = {5'b00000, r_cpha, r_cpol, r_en};
         2'd1:    w_regVal = {3'b000, w_sel, w_busy, r_ovr, r_txe, r_rxf};
         2'd2:    w_regVal = r_txBuf;
         default: w_regVal = r_rxBuf;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Disabling EN outranks a select edge so a frame can never start on a disabled block.
   always_comb begin
      w_nextState = r_state;
      w_start     = 1'b0;
      w_stop      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ssnFall && r_en && !w_enOff) begin
               w_nextState = ST_ACTIVE;
               w_start     = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (w_ssnRise || w_enOff) begin
               w_nextState = ST_IDLE;
               w_stop      = 1'b1;
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sclkSync <= 3'b000;
         r_mosiSync <= 2'b00;
         r_ssnSync  <= 3'b111;
      end else begin
         r_sclkSync <= {r_sclkSync[1:0], bus.sclk};
         r_mosiSync <= {r_mosiSync[0], bus.mosi};
         r_ssnSync  <= {r_ssnSync[1:0], bus.ss_n};
      end
   end

   // Later assignments override earlier ones: a CPU SSTX write beats a shift-register load on TXE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_en     <= 1'b0;
         r_cpol   <= 1'b0;
         r_cpha   <= 1'b0;
         r_rxf    <= 1'b0;
         r_txe    <= 1'b1;
         r_ovr    <= 1'b0;
         r_txBuf  <= 8'hFF;
         r_rxBuf  <= 8'h00;
         r_shRx   <= 8'h00;
         r_shTx   <= 8'h00;
         r_bitCnt <= 3'd0;
         r_rdData <= 8'h00;
      end else begin
         if (w_wrCon) begin
            r_en   <= bus.dout[0];
            r_cpol <= bus.dout[1];
            r_cpha <= bus.dout[2];
         end
         if (w_sample) begin
            r_shRx   <= w_rxByte;
            r_bitCnt <= r_bitCnt + 3'd1;
         end
         if (w_stop) begin
            r_bitCnt <= 3'd0;
         end
         if (w_loadTx) begin
            r_shTx <= r_txe ? 8'hFF : r_txBuf;
            r_txe  <= 1'b1;
         end else if (w_shift && (r_bitCnt != 3'd0)) begin
            r_shTx <= {r_shTx[6:0], 1'b0};
         end
         if (w_wrTx) begin
            r_txBuf <= bus.dout;
            r_txe   <= 1'b0;
         end
         if (w_rdRx) begin
            r_rxf <= 1'b0;
         end
         if (w_wrStat && bus.dout[2]) begin
            r_ovr <= 1'b0;
         end
         if (w_byteDone) begin
            if (!r_rxf || w_rdRx) begin
               r_rxBuf <= w_rxByte;
               r_rxf   <= 1'b1;
            end else begin
               r_ovr <= 1'b1;
            end
         end
         if (w_rd) begin
            r_rdData <= w_regVal;
         end
      end
   end

endmodule
